cpu_jtag_dr_scan_master: RTL and testbench

//   Initiator end of the virtual-JTAG link into the CPU debug module's TCK-domain block.

---
 rtl/cpu_jtag_dr_scan_master_if.sv | 23 ++
 rtl/cpu_jtag_dr_scan_master.sv | 192 +++++++++++++++++++
 tb/tb_cpu_jtag_dr_scan_master.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_jtag_dr_scan_master_if.sv
// Command/response handshake between a scan requester and the virtual-JTAG DR scan master.
// master: the requester issuing scans; slave: the scan engine.
interface cpu_jtag_dr_scan_master_if #(
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cpu_jtag_dr_scan_master.sv
// Virtual-JTAG initiator: runs UIR -> CDR -> SHIFT -> UDR -> RTI for one command,
// shifting cmd_data out on tdi and returning the tdo samples as rsp_data.
module cpu_jtag_dr_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int TCK_HALF = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  cpu_jtag_dr_scan_master_if.slave        scan_if,
  output logic                            tck,
  output logic                            tdi,
  input  logic                            tdo,
  output logic [1:0]                      ir_in,
  output logic                            vs_uir,
  output logic                            vs_cdr,
  output logic                            vs_sdr,
  output logic                            vs_udr,
  output logic                            jtag_rti
);

  localparam int HW = $clog2(TCK_HALF) + 1;
  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(TCK_HALF - 1);
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DR_WIDTH - 1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(DR_WIDTH);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_DONE
  } state_t;

  state_t              state_reg,    state_next;
  logic [HW-1:0]       half_cnt_reg, half_cnt_next;
  logic                phase_reg,    phase_next;
  logic [BW-1:0]       bit_cnt_reg,  bit_cnt_next;
  logic [DR_WIDTH-1:0] sr_reg,       sr_next;
  logic [DR_WIDTH-1:0] cap_reg,      cap_next;
  logic [DR_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [1:0]          ir_reg,       ir_next;

  logic [DR_WIDTH-1:0] sr_shift;
  logic [DR_WIDTH-1:0] cap_shift;
  logic                active;
  logic                half_end;
  logic                period_end;
  logic                sample_edge;
  logic                cmd_ready_c;
  logic                rsp_valid_c;

  // Outgoing word drains from bit 0; tdo samples enter at the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < DR_WIDTH; gi++) begin : g_shift
      if (gi == DR_WIDTH - 1) begin : g_msb
        assign sr_shift[gi]  = 1'b0;
        assign cap_shift[gi] = tdo;
      end else begin : g_low
        assign sr_shift[gi]  = sr_reg[gi+1];
        assign cap_shift[gi] = cap_reg[gi+1];
      end
    end
  endgenerate

  assign active      = (state_reg == ST_UIR) || (state_reg == ST_CDR) ||
                       (state_reg == ST_SHIFT) || (state_reg == ST_UDR) ||
                       (state_reg == ST_RTI);
  assign half_end    = (half_cnt_reg == HALF_LAST);
  assign period_end  = active && phase_reg && half_end;
  // tdo is taken at the close of the first tck-high cycle, after the target has had a full low half to settle.
  assign sample_edge = (state_reg == ST_SHIFT) && phase_reg && (half_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      half_cnt_reg <= '0;
      phase_reg    <= 1'b0;
      bit_cnt_reg  <= '0;
      sr_reg       <= '0;
      cap_reg      <= '0;
      rsp_data_reg <= '0;
      ir_reg       <= 2'b00;
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      phase_reg    <= phase_next;
      bit_cnt_reg  <= bit_cnt_next;
      sr_reg       <= sr_next;
      cap_reg      <= cap_next;
      rsp_data_reg <= rsp_data_next;
      ir_reg       <= ir_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg;
    phase_next    = phase_reg;
    bit_cnt_next  = bit_cnt_reg;
    sr_next       = sr_reg;
    cap_next      = cap_reg;
    rsp_data_next = rsp_data_reg;
    ir_next       = ir_reg;
    tck           = 1'b0;
    tdi           = 1'b0;
    vs_uir        = 1'b0;
    vs_cdr        = 1'b0;
    vs_sdr        = 1'b0;
    vs_udr        = 1'b0;
    jtag_rti      = 1'b0;
    cmd_ready_c   = 1'b0;
    rsp_valid_c   = 1'b0;

    if (active) begin
      tck = phase_reg;
      if (half_end) begin
        half_cnt_next = '0;
        phase_next    = ~phase_reg;
      end else begin
        half_cnt_next = half_cnt_reg + HALF_ONE;
      end
      if (period_end && (bit_cnt_reg != BIT_MAX)) begin
        bit_cnt_next = bit_cnt_reg + BIT_ONE;
      end
    end

    unique case (state_reg)
      ST_IDLE: begin
        jtag_rti    = 1'b1;
        cmd_ready_c = 1'b1;
        if (scan_if.cmd_valid) begin
          ir_next    = scan_if.cmd_ir;
          sr_next    = scan_if.cmd_data;
          state_next = ST_UIR;
        end
      end
      ST_UIR: begin
        vs_uir = 1'b1;
        if (period_end) state_next = ST_CDR;
      end
      ST_CDR: begin
        vs_cdr = 1'b1;
        if (period_end) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        vs_sdr = 1'b1;
        tdi    = sr_reg[0];
        if (sample_edge) cap_next = cap_shift;
        if (period_end) begin
          sr_next = sr_shift;
          if (bit_cnt_reg == BIT_LAST) state_next = ST_UDR;
        end
      end
      ST_UDR: begin
        vs_udr = 1'b1;
        if (period_end) state_next = ST_RTI;
      end
      ST_RTI: begin
        jtag_rti = 1'b1;
        if (period_end) begin
          rsp_data_next = cap_reg;
          state_next    = ST_DONE;
        end
      end
      ST_DONE: begin
        jtag_rti    = 1'b1;
        rsp_valid_c = 1'b1;
        // Returning through IDLE keeps a new command from being taken on the response handshake cycle.
        if (scan_if.rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_next != state_reg) begin
      half_cnt_next = '0;
      phase_next    = 1'b0;
      bit_cnt_next  = '0;
    end
  end

  assign ir_in             = ir_reg;
  assign scan_if.cmd_ready = cmd_ready_c;
  assign scan_if.rsp_valid = rsp_valid_c;
  assign scan_if.rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_cpu_jtag_dr_scan_master.sv
// Randomized self-checking bench: two scan masters (TCK_HALF 1 and 2) against a word-level model.
module tb_cpu_jtag_dr_scan_master;
  localparam int DW  = 38;
  localparam int TH1 = 1;
  localparam int TH2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          use_h1 = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [1:0]    cmd_ir = 2'b00;
  logic [DW-1:0] cmd_data = '0;
  logic          tdo_inv = 1'b0;
  logic          tdo_const_en = 1'b0;
  logic          tdo_const_val = 1'b0;

  int checks = 0;
  int errors = 0;

  cpu_jtag_dr_scan_master_if #(.DR_WIDTH(DW)) if_h1 ();
  cpu_jtag_dr_scan_master_if #(.DR_WIDTH(DW)) if_h2 ();

  logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic       tck2, tdi2, tdo2, uir2, cdr2, sdr2, udr2, rti2;
  logic [1:0] ir1, ir2;

  assign if_h1.cmd_valid = use_h1 & cmd_valid;
  assign if_h1.cmd_ir    = cmd_ir;
  assign if_h1.cmd_data  = cmd_data;
  assign if_h1.rsp_ready = use_h1 & rsp_ready;
  assign if_h2.cmd_valid = ~use_h1 & cmd_valid;
  assign if_h2.cmd_ir    = cmd_ir;
  assign if_h2.cmd_data  = cmd_data;
  assign if_h2.rsp_ready = ~use_h1 & rsp_ready;

  cpu_jtag_dr_scan_master #(.DR_WIDTH(DW), .TCK_HALF(TH1)) dut_h1 (
    .clk(clk), .reset(reset), .scan_if(if_h1),
    .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir1),
    .vs_uir(uir1), .vs_cdr(cdr1), .vs_sdr(sdr1), .vs_udr(udr1), .jtag_rti(rti1)
  );

  cpu_jtag_dr_scan_master #(.DR_WIDTH(DW), .TCK_HALF(TH2)) dut_h2 (
    .clk(clk), .reset(reset), .scan_if(if_h2),
    .tck(tck2), .tdi(tdi2), .tdo(tdo2), .ir_in(ir2),
    .vs_uir(uir2), .vs_cdr(cdr2), .vs_sdr(sdr2), .vs_udr(udr2), .jtag_rti(rti2)
  );

  // Target model: tdo is tdi (optionally inverted) registered on tck rise, or a constant.
  logic tdo1_q = 1'b0;
  logic tdo2_q = 1'b0;
  always @(posedge tck1) tdo1_q <= tdi1 ^ tdo_inv;
  always @(posedge tck2) tdo2_q <= tdi2 ^ tdo_inv;
  assign tdo1 = tdo_const_en ? tdo_const_val : tdo1_q;
  assign tdo2 = tdo_const_en ? tdo_const_val : tdo2_q;

  logic          o_tck, o_tdi, o_uir, o_cdr, o_sdr, o_udr, o_rti, o_cmd_ready, o_rsp_valid;
  logic [1:0]    o_ir;
  logic [DW-1:0] o_rsp_data;
  assign o_tck       = use_h1 ? tck1 : tck2;
  assign o_tdi       = use_h1 ? tdi1 : tdi2;
  assign o_uir       = use_h1 ? uir1 : uir2;
  assign o_cdr       = use_h1 ? cdr1 : cdr2;
  assign o_sdr       = use_h1 ? sdr1 : sdr2;
  assign o_udr       = use_h1 ? udr1 : udr2;
  assign o_rti       = use_h1 ? rti1 : rti2;
  assign o_ir        = use_h1 ? ir1 : ir2;
  assign o_cmd_ready = use_h1 ? if_h1.cmd_ready : if_h2.cmd_ready;
  assign o_rsp_valid = use_h1 ? if_h1.rsp_valid : if_h2.rsp_valid;
  assign o_rsp_data  = use_h1 ? if_h1.rsp_data : if_h2.rsp_data;

  // Measurements of one scan: index 0..4 = UIR, CDR, SHIFT, UDR, RTI.
  int            m_lat;
  int            m_cyc [5];
  int            m_rise [5];
  logic [DW-1:0] m_tdi_bits;
  int            m_tdi_n;
  bit            m_ir_ok;
  bit            m_onehot_ok;

  function automatic logic [DW-1:0] exp_capture(input logic [DW-1:0] d);
    if (tdo_const_en) return {DW{tdo_const_val}};
    return d ^ {DW{tdo_inv}};
  endfunction

  function automatic int exp_latency();
    return (DW + 4) * 2 * (use_h1 ? TH1 : TH2);
  endfunction

  task automatic start_cmd(input logic [1:0] ir, input logic [DW-1:0] d);
    @(negedge clk);
    cmd_ir    = ir;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic measure_scan(input logic [1:0] exp_ir);
    logic prev_tck;
    logic rise;
    int   edges;
    bit   timed_out;
    prev_tck = 1'b0;
    edges = 0;
    timed_out = 1'b0;
    m_tdi_bits = '0;
    m_tdi_n = 0;
    m_ir_ok = 1'b1;
    m_onehot_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_cyc[i] = 0;
      m_rise[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (o_rsp_valid) break;
      if (edges > 2000) begin
        timed_out = 1'b1;
        break;
      end
      if (o_ir !== exp_ir) m_ir_ok = 1'b0;
      if ($countones({o_uir, o_cdr, o_sdr, o_udr}) > 1) m_onehot_ok = 1'b0;
      rise = o_tck & ~prev_tck;
      if (o_uir) begin m_cyc[0]++; if (rise) m_rise[0]++; end
      if (o_cdr) begin m_cyc[1]++; if (rise) m_rise[1]++; end
      if (o_sdr) begin m_cyc[2]++; if (rise) m_rise[2]++; end
      if (o_udr) begin m_cyc[3]++; if (rise) m_rise[3]++; end
      if (o_rti) begin m_cyc[4]++; if (rise) m_rise[4]++; end
      if (rise && o_sdr) begin
        if (m_tdi_n < DW) m_tdi_bits[m_tdi_n] = o_tdi;
        m_tdi_n++;
      end
      prev_tck = o_tck;
      @(posedge clk);
      edges++;
    end
    m_lat = edges;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL scan_timeout: rsp_valid not seen within %0d edges, required %0d", edges, exp_latency());
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (o_tck !== 1'b0) begin errors++; $display("FAIL reset_tck: got %b required 0", o_tck); end
    checks++; if ({o_uir, o_cdr, o_sdr, o_udr} !== 4'b0000) begin errors++; $display("FAIL reset_vs: got %b required 0000", {o_uir, o_cdr, o_sdr, o_udr}); end
    checks++; if (o_rti !== 1'b1) begin errors++; $display("FAIL reset_rti: got %b required 1", o_rti); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", o_cmd_ready); end
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", o_rsp_valid); end
    checks++; if (o_ir !== 2'b00 || o_rsp_data !== '0 || o_tdi !== 1'b0) begin
      errors++; $display("FAIL reset_regs: ir %b rsp %h tdi %b required 0", o_ir, o_rsp_data, o_tdi);
    end
    $display("reset: tck=%b vs=%b rti=%b cmd_ready=%b rsp_valid=%b", o_tck, {o_uir, o_cdr, o_sdr, o_udr}, o_rti, o_cmd_ready, o_rsp_valid);
  endtask

  task automatic test_loopback();
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    d = 38'h2A_5A5A_C3C3;
    use_h1 = 1'b1;
    tdo_const_en = 1'b0;
    tdo_inv = 1'b0;
    exp = exp_capture(d);
    start_cmd(2'b01, d);
    measure_scan(2'b01);
    checks++; if (m_lat != 84) begin errors++; $display("FAIL loopback_latency: got %0d required 84", m_lat); end
    checks++; if (o_rsp_data !== exp) begin errors++; $display("FAIL loopback_data: got %h required %h", o_rsp_data, exp); end
    checks++; if (m_tdi_bits !== d) begin errors++; $display("FAIL loopback_tdi_order: got %h required %h", m_tdi_bits, d); end
    checks++; if (m_rise[2] != DW) begin errors++; $display("FAIL loopback_sdr_rises: got %0d required %0d", m_rise[2], DW); end
    $display("loopback: data=%h rsp=%h latency=%0d", d, o_rsp_data, m_lat);
    consume();
    use_h1 = 1'b0;
  endtask

  task automatic test_sequence();
    logic [63:0]   r;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    r = {$urandom(), $urandom()};
    d = r[DW-1:0];
    exp = exp_capture(d);
    start_cmd(2'b10, d);
    measure_scan(2'b10);
    checks++; if (!m_ir_ok) begin errors++; $display("FAIL seq_ir_in: ir_in deviated from required 10 during scan"); end
    checks++; if (m_cyc[0] != 4 || m_cyc[1] != 4 || m_cyc[3] != 4 || m_cyc[4] != 4) begin
      errors++; $display("FAIL seq_state_len: uir %0d cdr %0d udr %0d rti %0d required 4 each", m_cyc[0], m_cyc[1], m_cyc[3], m_cyc[4]);
    end
    checks++; if (m_cyc[2] != 152) begin errors++; $display("FAIL seq_sdr_len: got %0d required 152", m_cyc[2]); end
    checks++; if (m_rise[2] != 38) begin errors++; $display("FAIL seq_sdr_rises: got %0d required 38", m_rise[2]); end
    checks++; if (m_rise[0] != 1 || m_rise[1] != 1 || m_rise[3] != 1 || m_rise[4] != 1) begin
      errors++; $display("FAIL seq_rises: uir %0d cdr %0d udr %0d rti %0d required 1 each", m_rise[0], m_rise[1], m_rise[3], m_rise[4]);
    end
    checks++; if (!m_onehot_ok) begin errors++; $display("FAIL seq_onehot: vs_* overlapped, required one-hot or zero"); end
    checks++; if (m_lat != exp_latency()) begin errors++; $display("FAIL seq_latency: got %0d required %0d", m_lat, exp_latency()); end
    checks++; if (o_rsp_data !== exp) begin errors++; $display("FAIL seq_data: got %h required %h", o_rsp_data, exp); end
    $display("sequence: ir=10 uir=%0d cdr=%0d sdr=%0d/%0d rises udr=%0d latency=%0d", m_cyc[0], m_cyc[1], m_cyc[2], m_rise[2], m_cyc[3], m_lat);
    consume();
  endtask

  task automatic test_const_tdo();
    logic [63:0]   r;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    for (int v = 1; v >= 0; v--) begin
      tdo_const_en = 1'b1;
      tdo_const_val = v[0];
      r = {$urandom(), $urandom()};
      d = r[DW-1:0];
      exp = exp_capture(d);
      start_cmd(2'(v + 1), d);
      measure_scan(2'(v + 1));
      checks++; if (o_rsp_data !== exp) begin errors++; $display("FAIL const_tdo_%0d: got %h required %h", v, o_rsp_data, exp); end
      $display("const_tdo: tdo=%0d rsp=%h", v, o_rsp_data);
      consume();
    end
    tdo_const_en = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0]   r;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    logic [1:0]    ir;
    for (int n = 0; n < 6; n++) begin
      use_h1 = 1'($urandom_range(1, 0));
      tdo_inv = 1'($urandom_range(1, 0));
      ir = 2'($urandom_range(3, 0));
      r = {$urandom(), $urandom()};
      d = r[DW-1:0];
      exp = exp_capture(d);
      start_cmd(ir, d);
      measure_scan(ir);
      checks++; if (o_rsp_data !== exp) begin errors++; $display("FAIL rand_data_%0d: got %h required %h", n, o_rsp_data, exp); end
      checks++; if (m_tdi_bits !== d || m_tdi_n != DW) begin errors++; $display("FAIL rand_tdi_%0d: got %h (%0d bits) required %h", n, m_tdi_bits, m_tdi_n, d); end
      checks++; if (m_lat != exp_latency() || !m_ir_ok) begin errors++; $display("FAIL rand_timing_%0d: latency %0d required %0d ir_ok %b", n, m_lat, exp_latency(), m_ir_ok); end
      consume();
      @(negedge clk);
      checks++; if (o_ir !== ir || o_rsp_data !== exp || o_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rand_persist_%0d: ir %b rsp %h valid %b required ir %b rsp %h valid 0", n, o_ir, o_rsp_data, o_rsp_valid, ir, exp);
      end
      $display("random %0d: h1=%b inv=%b ir=%b data=%h rsp=%h latency=%0d", n, use_h1, tdo_inv, ir, d, o_rsp_data, m_lat);
    end
    use_h1 = 1'b0;
    tdo_inv = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0]   r;
    logic [DW-1:0] da, db, exp_a, exp_b;
    r = {$urandom(), $urandom()};
    da = r[DW-1:0];
    r = {$urandom(), $urandom()};
    db = r[DW-1:0];
    exp_a = exp_capture(da);
    exp_b = exp_capture(db);
    start_cmd(2'b11, da);
    measure_scan(2'b11);
    cmd_ir = 2'b01;
    cmd_data = db;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== exp_a || o_cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: valid %b rsp %h cmd_ready %b required 1 %h 0", c, o_rsp_valid, o_rsp_data, o_cmd_ready, exp_a);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_uir !== 1'b0) begin
      errors++; $display("FAIL bp_after_handshake: valid %b cmd_ready %b vs_uir %b required 0 1 0", o_rsp_valid, o_cmd_ready, o_uir);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    measure_scan(2'b01);
    checks++; if (m_lat != exp_latency() || m_cyc[0] != 2 * TH2) begin
      errors++; $display("FAIL bp_second_accept: latency %0d uir %0d required %0d %0d", m_lat, m_cyc[0], exp_latency(), 2 * TH2);
    end
    checks++; if (o_rsp_data !== exp_b) begin errors++; $display("FAIL bp_second_data: got %h required %h", o_rsp_data, exp_b); end
    $display("back_to_back: rsp_a=%h rsp_b=%h latency_b=%0d", exp_a, o_rsp_data, m_lat);
    consume();
  endtask

  task automatic test_reset_mid();
    logic prev_tck;
    int   rises;
    int   waited;
    int   spurious;
    prev_tck = 1'b0;
    rises = 0;
    waited = 0;
    start_cmd(2'b10, 38'h15_F0F0_0F0F);
    while (rises < 10 && waited < 2000) begin
      @(negedge clk);
      if (o_tck && !prev_tck && o_sdr) rises++;
      prev_tck = o_tck;
      waited++;
    end
    checks++; if (rises != 10) begin errors++; $display("FAIL midreset_reach: got %0d shift rises required 10", rises); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (o_tck !== 1'b0 || {o_uir, o_cdr, o_sdr, o_udr} !== 4'b0000 || o_tdi !== 1'b0) begin
      errors++; $display("FAIL midreset_jtag: tck %b vs %b tdi %b required 0 0000 0", o_tck, {o_uir, o_cdr, o_sdr, o_udr}, o_tdi);
    end
    checks++; if (o_rti !== 1'b1 || o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_handshake: rti %b cmd_ready %b rsp_valid %b required 1 1 0", o_rti, o_cmd_ready, o_rsp_valid);
    end
    checks++; if (o_ir !== 2'b00 || o_rsp_data !== '0) begin
      errors++; $display("FAIL midreset_regs: ir %b rsp %h required 0", o_ir, o_rsp_data);
    end
    reset = 1'b0;
    spurious = 0;
    repeat (250) begin
      @(negedge clk);
      if (o_rsp_valid) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL midreset_no_rsp: rsp_valid seen %0d cycles required 0", spurious); end
    $display("reset_mid: aborted at shift bit %0d, spurious rsp_valid cycles=%0d", rises, spurious);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_sequence();
    test_const_tdo();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
